// File: rtl/lampFPU_pkg.sv
// lampFPU_pkg: shared bfloat16 field widths, the qNaN constant, the operand classifier and the log arbiter state type.
// Imported by lamp_log_arbiter and by anything that talks to it.
package lampFPU_pkg;
  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_QNAN = 16'h7FC0;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} lampLogArbState_t;
  typedef struct packed {
    logic isZ;
    logic isInf;
    logic isSNAN;
    logic isQNAN;
    logic isDN;
  } lampOpClass_t;
  // Classify a bfloat16 operand from its exponent and fraction; the sign never affects the class.
  function automatic lampOpClass_t FUNC_checkOperand(
    input logic [LAMP_FLOAT_E_DW-1:0] e,
    input logic [LAMP_FLOAT_F_DW-1:0] f
  );
    logic e_zero, e_ones, f_zero;
    e_zero = ~|e;
    e_ones = &e;
    f_zero = ~|f;
    return '{isZ:    e_zero & f_zero,
             isInf:  e_ones & f_zero,
             isSNAN: e_ones & ~f_zero & ~f[LAMP_FLOAT_F_DW-1],
             isQNAN: e_ones & f[LAMP_FLOAT_F_DW-1],
             isDN:   e_zero & ~f_zero};
  endfunction
endpackage

// File: rtl/lamp_rr_picker.sv
// lamp_rr_picker: combinational round-robin picker; the first request at or above ptr (wrapping) wins.
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot, zero when no request), grant_id (index of grant).
module lamp_rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_id
);
  logic [W-1:0] w_idx;
  // Walk from the farthest candidate back to ptr so the nearest valid request overwrites the rest.
  always_comb begin
    grant = '0;
    grant_id = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = W'((int'(ptr) + k) % N);
      if (req[w_idx]) begin
        grant = '0;
        grant[w_idx] = 1'b1;
        grant_id = w_idx;
      end
    end
  end
endmodule

// File: rtl/lamp_log_arbiter.sv
// lamp_log_arbiter: round-robin arbiter/sequencer sharing one lampFPU_log among NUM_REQ requesters.
// Requests: req_valid_i/req_op_i in, req_ready_o one-hot accept (IDLE only).
// Log unit: doLog_o, registered operand fields and class flags out; result fields and status in.
// Response: rsp_valid_o/rsp_ready_i handshake with rsp_id_o, rsp_res_o, rsp_ovf_o/unf/rnd and rsp_timeout_o.
// Optional watchdog: define LAMP_LOG_ARB_TIMEOUT_EN to substitute a qNaN after TIMEOUT_CYC BUSY cycles.
// rst is asynchronous and active-low.
module lamp_log_arbiter
  import lampFPU_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  input  logic [NUM_REQ-1:0][LAMP_FLOAT_DW-1:0]  req_op_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  output logic                                   doLog_o,
  output logic                                   s_op_o,
  output logic [LAMP_FLOAT_E_DW-1:0]             e_op_o,
  output logic [LAMP_FLOAT_F_DW-1:0]             f_op_o,
  output logic                                   isZ_op_o,
  output logic                                   isInf_op_o,
  output logic                                   isSNAN_op_o,
  output logic                                   isQNAN_op_o,
  output logic                                   isDN_op_o,
  input  logic                                   s_res_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]             e_res_i,
  input  logic [LAMP_FLOAT_F_DW-1:0]             f_res_i,
  input  logic                                   valid_i,
  input  logic                                   isOverflow_i,
  input  logic                                   isUnderflow_i,
  input  logic                                   isToRound_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [ID_W-1:0]                        rsp_id_o,
  output logic [LAMP_FLOAT_DW-1:0]               rsp_res_o,
  output logic                                   rsp_ovf_o,
  output logic                                   rsp_unf_o,
  output logic                                   rsp_rnd_o,
  output logic                                   rsp_timeout_o
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("lamp_log_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end
  lampLogArbState_t         r_state;
  logic [ID_W-1:0]          r_ptr;
  logic [ID_W-1:0]          r_id;
  logic [LAMP_FLOAT_DW-1:0] r_op;
  lampOpClass_t             r_cls;
  logic [LAMP_FLOAT_DW-1:0] r_res;
  logic [2:0]               r_sts;
  logic [NUM_REQ-1:0]       w_grant;
  logic [ID_W-1:0]          w_grant_id;
  logic [LAMP_FLOAT_DW-1:0] w_op;
  lampOpClass_t             w_cls;
`ifdef LAMP_LOG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_to;
  assign rsp_timeout_o = r_to;
`else
  assign rsp_timeout_o = 1'b0;
`endif
  lamp_rr_picker #(.N(NUM_REQ), .W(ID_W)) u_picker (
    .req      (req_valid_i),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );
  assign w_op        = req_op_i[w_grant_id];
  assign w_cls       = FUNC_checkOperand(w_op[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW], w_op[LAMP_FLOAT_F_DW-1:0]);
  assign req_ready_o = (r_state == IDLE) ? w_grant : '0;
  assign {s_op_o, e_op_o, f_op_o} = r_op;
  assign {isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o} = r_cls;
  assign rsp_id_o  = r_id;
  assign rsp_res_o = r_res;
  assign {rsp_ovf_o, rsp_unf_o, rsp_rnd_o} = r_sts;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_op        <= '0;
      r_cls       <= '0;
      r_res       <= '0;
      r_sts       <= '0;
      doLog_o     <= 1'b0;
      rsp_valid_o <= 1'b0;
`ifdef LAMP_LOG_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_to        <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (|w_grant) begin
          r_state <= BUSY;
          doLog_o <= 1'b1;
          r_id    <= w_grant_id;
          r_op    <= w_op;
          r_cls   <= w_cls;
`ifdef LAMP_LOG_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        BUSY: begin
          if (valid_i) begin
            r_state     <= RESP;
            doLog_o     <= 1'b0;
            rsp_valid_o <= 1'b1;
            r_res       <= {s_res_i, e_res_i, f_res_i};
            r_sts       <= {isOverflow_i, isUnderflow_i, isToRound_i};
`ifdef LAMP_LOG_ARB_TIMEOUT_EN
            r_to        <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_state     <= RESP;
            doLog_o     <= 1'b0;
            rsp_valid_o <= 1'b1;
            r_res       <= LAMP_FLOAT_QNAN;
            r_sts       <= '0;
            r_to        <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
`endif
          end
        end
        RESP: if (rsp_ready_i) begin
          r_state     <= IDLE;
          rsp_valid_o <= 1'b0;
          r_ptr       <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lamp_log_arbiter.sv
// tb_lamp_log_arbiter: directed bench for lamp_log_arbiter with NUM_REQ=4; the log unit is played by the bench.
module tb_lamp_log_arbiter;
  import lampFPU_pkg::*;
  localparam int N = 4;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N-1:0][15:0] req_op_i = '0;
  logic [N-1:0]      req_ready_o;
  logic              doLog_o, s_op_o;
  logic [7:0]        e_op_o;
  logic [6:0]        f_op_o;
  logic              isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o;
  logic              s_res_i = 1'b0;
  logic [7:0]        e_res_i = '0;
  logic [6:0]        f_res_i = '0;
  logic              valid_i = 1'b0, isOverflow_i = 1'b0, isUnderflow_i = 1'b0, isToRound_i = 1'b0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [1:0]        rsp_id_o;
  logic [15:0]       rsp_res_o;
  logic              rsp_ovf_o, rsp_unf_o, rsp_rnd_o, rsp_timeout_o;
  logic [21:0]       op_vec;
  logic [22:0]       rsp_vec;
  int                n_chk = 0;
  int                n_fail = 0;

  assign op_vec  = {doLog_o, s_op_o, e_op_o, f_op_o, isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o, isDN_op_o};
  assign rsp_vec = {rsp_valid_o, rsp_id_o, rsp_res_o, rsp_ovf_o, rsp_unf_o, rsp_rnd_o, rsp_timeout_o};

  always #5 clk = ~clk;

  lamp_log_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_ready_o(req_ready_o),
    .doLog_o(doLog_o), .s_op_o(s_op_o), .e_op_o(e_op_o), .f_op_o(f_op_o),
    .isZ_op_o(isZ_op_o), .isInf_op_o(isInf_op_o), .isSNAN_op_o(isSNAN_op_o),
    .isQNAN_op_o(isQNAN_op_o), .isDN_op_o(isDN_op_o),
    .s_res_i(s_res_i), .e_res_i(e_res_i), .f_res_i(f_res_i),
    .valid_i(valid_i), .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i), .isToRound_i(isToRound_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o), .rsp_res_o(rsp_res_o),
    .rsp_ovf_o(rsp_ovf_o), .rsp_unf_o(rsp_unf_o), .rsp_rnd_o(rsp_rnd_o), .rsp_timeout_o(rsp_timeout_o)
  );

  // One complete transaction from the current point in an IDLE cycle: request, BUSY for lat cycles,
  // RESP held for stall extra cycles (with a bogus valid_i the arbiter must ignore), then consume.
  task automatic run_op(input logic [1:0] id, input logic [15:0] op, input logic [15:0] res,
                        input logic [2:0] st, input int lat, input logic [4:0] cls, input int stall);
    logic [N-1:0] g;
    g = '0;
    g[id] = 1'b1;
    req_valid_i[id] = 1'b1;
    req_op_i[id] = op;
    #1;
    n_chk++;
    if (req_ready_o !== g) begin
      n_fail++;
      $display("FAIL grant id%0d: req_ready_o=%b want %b", id, req_ready_o, g);
    end
    @(negedge clk);
    req_valid_i[id] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      if (c == lat) begin
        valid_i = 1'b1;
        {s_res_i, e_res_i, f_res_i} = res;
        {isOverflow_i, isUnderflow_i, isToRound_i} = st;
      end
      #1;
      n_chk++;
      if (op_vec !== {1'b1, op, cls} || req_ready_o !== '0) begin
        n_fail++;
        $display("FAIL busy id%0d cyc%0d: op_vec=%h ready=%b want %h ready=0", id, c, op_vec, req_ready_o, {1'b1, op, cls});
      end
    end
    @(negedge clk);
    valid_i = (stall > 0);
    {s_res_i, e_res_i, f_res_i} = ~res;
    {isOverflow_i, isUnderflow_i, isToRound_i} = ~st;
    for (int c = 0; c <= stall; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_chk++;
      if (rsp_vec !== {1'b1, id, res, st, 1'b0} || doLog_o !== 1'b0 || req_ready_o !== '0) begin
        n_fail++;
        $display("FAIL resp id%0d cyc%0d: rsp_vec=%h doLog=%b ready=%b want %h doLog=0 ready=0",
                 id, c, rsp_vec, doLog_o, req_ready_o, {1'b1, id, res, st, 1'b0});
      end
    end
    valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    #1;
    n_chk++;
    if (rsp_valid_o !== 1'b0 || doLog_o !== 1'b0) begin
      n_fail++;
      $display("FAIL consume id%0d: rsp_valid=%b doLog=%b want 0 0", id, rsp_valid_o, doLog_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid_i = 4'b0100;
    @(negedge clk);
    #1;
    n_chk++;
    if (op_vec !== '0 || rsp_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: op_vec=%h rsp_vec=%h want 0 0", op_vec, rsp_vec);
    end
    n_chk++;
    if (req_ready_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready_o=%b want 0100", req_ready_o);
    end
    req_valid_i = '0;
    rst = 1'b1;
  endtask

  task automatic test_single;
    run_op(2'd0, 16'h3F80, 16'h0000, 3'b000, 3, 5'b00000, 0);
  endtask

  task automatic test_round_robin;
    rst = 1'b0;
    req_valid_i = 4'b0011;
    req_op_i[0] = 16'h4000;
    req_op_i[1] = 16'h4080;
    @(negedge clk);
    rst = 1'b1;
    run_op(2'd0, 16'h4000, 16'h3F80, 3'b000, 2, 5'b00000, 0);
    n_chk++;
    if (req_ready_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL rr_second_ready: req_ready_o=%b want 0010", req_ready_o);
    end
    run_op(2'd1, 16'h4080, 16'h4000, 3'b000, 1, 5'b00000, 0);
  endtask

  task automatic test_no_gap;
    run_op(2'd1, 16'h0000, 16'hFF80, 3'b000, 2, 5'b10000, 0);
  endtask

  task automatic test_wrap;
    req_valid_i = 4'b1001;
    req_op_i[0] = 16'h0001;
    run_op(2'd3, 16'h7F81, 16'h7FC0, 3'b000, 1, 5'b00100, 0);
    n_chk++;
    if (req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_ready: req_ready_o=%b want 0001", req_ready_o);
    end
    run_op(2'd0, 16'h0001, 16'hC2B0, 3'b011, 3, 5'b00001, 0);
  endtask

  task automatic test_stall;
    req_valid_i[0] = 1'b1;
    req_op_i[0] = 16'h3F80;
    run_op(2'd2, 16'h7F80, 16'h7F80, 3'b100, 2, 5'b01000, 5);
    n_chk++;
    if (req_ready_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_release_ready: req_ready_o=%b want 0001", req_ready_o);
    end
    run_op(2'd0, 16'h3F80, 16'h0000, 3'b000, 1, 5'b00000, 0);
  endtask

  task automatic test_reset_mid;
    req_valid_i[2] = 1'b1;
    req_op_i[2] = 16'hBF80;
    #1;
    n_chk++;
    if (req_ready_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_grant: req_ready_o=%b want 0100", req_ready_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (op_vec !== '0 || rsp_vec !== '0 || req_ready_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_reset: op_vec=%h rsp_vec=%h ready=%b want 0 0 0100", op_vec, rsp_vec, req_ready_o);
    end
    @(negedge clk);
    req_valid_i = '0;
    rst = 1'b1;
    run_op(2'd2, 16'hFFC0, 16'hFFC0, 3'b000, 2, 5'b00010, 0);
  endtask

  task automatic test_timeout;
    int busy;
    busy = 0;
    req_valid_i[0] = 1'b1;
    req_op_i[0] = 16'h3F80;
    @(negedge clk);
    req_valid_i = '0;
    #1;
    for (int c = 0; c < 1000 && !rsp_valid_o; c++) begin
      if (doLog_o) busy++;
      @(negedge clk);
      #1;
    end
`ifdef LAMP_LOG_ARB_TIMEOUT_EN
    n_chk++;
    if (busy != 64 || rsp_vec !== {1'b1, 2'd0, 16'h7FC0, 3'b000, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout: busy=%0d rsp_vec=%h want 64 %h", busy, rsp_vec, {1'b1, 2'd0, 16'h7FC0, 3'b000, 1'b1});
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
`else
    n_chk++;
    if (busy != 1000 || rsp_valid_o !== 1'b0 || rsp_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout: busy=%0d rsp_valid=%b timeout=%b want 1000 0 0", busy, rsp_valid_o, rsp_timeout_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_gap();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lamp_log_arbiter.md
# lamp_log_arbiter

Round-robin arbiter and sequencer that shares one `lampFPU_log` instance among `NUM_REQ` requesters. It accepts packed bfloat16 operands, classifies them, drives the log unit's level-held `doLog_i` / `valid_o` protocol, and returns each result with the requester ID over a ready/valid response channel. It sits between the issue logic of the FPU clients and the single log datapath.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8).
- `ID_W`, `$clog2(NUM_REQ)` (min 1), requester ID width.
- `TIMEOUT_CYC`, 64, watchdog limit in cycles. Used only with `LAMP_LOG_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester operand valid.
- `req_op_i`  in  NUM_REQ×16  per-requester packed {s,e[7:0],f[6:0]}.
- `req_ready_o`  out  NUM_REQ  one-hot accept.
- `doLog_o`  out  1  to log unit `doLog_i`.
- `s_op_o`/`e_op_o`/`f_op_o`  out  1/8/7  registered operand fields.
- `isZ_op_o`, `isInf_op_o`, `isSNAN_op_o`, `isQNAN_op_o`, `isDN_op_o`  out  1 each  registered class flags from `FUNC_checkOperand`.
- `s_res_i`/`e_res_i`/`f_res_i`  in  1/8/7  log unit result.
- `valid_i`, `isOverflow_i`, `isUnderflow_i`, `isToRound_i`  in  1 each  log unit status.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accept.
- `rsp_id_o`  out  ID_W  requester that issued the result.
- `rsp_res_o`  out  16  packed result.
- `rsp_ovf_o`, `rsp_unf_o`, `rsp_rnd_o`  out  1 each  captured status.
- `rsp_timeout_o`  out  1  result is a watchdog substitute.

## Operation
- FSM states are IDLE, BUSY and RESP. `rr_ptr` (ID_W) holds round-robin priority.
- IDLE:
  - Grant is the first requester with `req_valid_i` set, searching from `rr_ptr` upward with wrap.
  - `req_ready_o[grant]=1` combinationally. All other ready bits are 0.
  - On handshake: register the operand fields, the class flags, and the ID. Go to BUSY.
- BUSY:
  - `doLog_o=1` and the operand outputs are held stable.
  - On the first cycle with `valid_i=1`: capture the result and status, then go to RESP.
- RESP:
  - `rsp_valid_o=1` and all response outputs are held stable.
  - On `rsp_ready_i=1`: set `rr_ptr` to ID+1 mod NUM_REQ and go to IDLE.
- `req_ready_o` is all-zero in BUSY and RESP.
- `valid_i` is ignored outside BUSY.
- If `rr_ptr`'s requester is not valid, lower-priority valid requesters are still granted. No cycle is wasted.
- Reset mid-operation:
  - Everything clears immediately: IDLE, `rr_ptr=0`, and all outputs 0.
  - An in-flight result is discarded. The log unit is reset by the same `rst`.
- Reset values: `req_ready_o` follows IDLE combinational logic; every other output is 0.

## Timing
- Accept at edge N. `doLog_o` rises after edge N.
- If `valid_i` is seen at edge N+k, `rsp_valid_o` rises and `doLog_o` falls after edge N+k.
- Issue-to-response latency is therefore the log unit latency + 1 cycle.
- Response consumed at edge M: IDLE after M, with the earliest next accept at edge M+1.
- `doLog_o` is low for at least 2 cycles between operations (RESP + IDLE).
- Back-to-back throughput: one op per (log latency + 3) cycles with `rsp_ready_i` held high.

## Configuration
- Macro `LAMP_LOG_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A cycle counter clears on entry to BUSY.
  - If `valid_i` has not arrived by the end of cycle `TIMEOUT_CYC` in BUSY, `doLog_o` drops and the FSM goes to RESP.
  - That response carries `rsp_res_o=16'h7FC0` (qNaN), `rsp_timeout_o=1`, and ovf/unf/rnd = 0.
- Without the macro: no counter exists, `rsp_timeout_o` is tied to 0, and BUSY waits indefinitely.

## Structure
- `lampFPU_pkg` holds:
  - the `LAMP_FLOAT_*_DW` widths
  - `FUNC_checkOperand`
  - a new `LAMP_FLOAT_QNAN` constant (16'h7FC0)
  - the state enum `lampLogArbState_t`
- One sub-module, `lamp_rr_picker`: a combinational round-robin priority picker taking `req`, `ptr` and producing a one-hot `grant` and a `grant_id`.

## Test plan
- Req0 op 16'h3F80 (1.0), real `lampFPU_log` → `rsp_id_o=0`, `rsp_res_o=16'h0000`, `doLog_o` high exactly from accept to `valid_i`.
- Req0 = 16'h4000 (2.0) and req1 = 16'h4080 (4.0), both valid from reset release → req0 served first (16'h3F80), then req1 (16'h4000). `rr_ptr` ends at 0.
- Hold `rsp_ready_i=0` for 5 cycles during RESP → response outputs are stable, `req_ready_o=0`, no new `doLog_o`. Release → IDLE the next cycle.
- Req1 only, with NUM_REQ=4 and `rr_ptr=2` → req1 is granted in the same cycle, with no idle gap.
- Assert `rst` low two cycles into BUSY → all outputs are 0 immediately. After release, a fresh op completes correctly.
- Macro on, stub log unit never asserts `valid_i` → response 16'h7FC0 with `rsp_timeout_o=1` after `TIMEOUT_CYC`=64 BUSY cycles. With the macro off, no response after 1000 cycles.
